// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: measurement sequencer for an equal-precision frequency meter.
// The real gate opens and closes on synchronized Fx rising edges around a
// preset gate time. Inside it, CLK cycles (Nb) and Fx periods (Nx) are
// counted. The result pair is offered downstream over a valid/ready handshake.
//
// Handshake: res_valid is high for the whole HOLD state, and Nx_out/Nb_out/
// timeout are stable while it is high. A transfer happens on a CLK edge where
// res_valid and res_ready are both high. res_valid is low from the next cycle.
// res_ready is ignored while res_valid is low.
//
// Optional feature: define FREQ_AUTO_RESTART_EN for continuous measurement.
// After each handshake the sequencer re-arms without a start pulse. After RST
// it still needs one start pulse.
//
// o_dbg_state exposes the FSM state for checkers.
module freq_gate_ctrl #(
    parameter int GATE_TICKS    = 50_000_000,
    parameter int TIMEOUT_TICKS = 100_000_000,
    parameter int CNT_W         = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Fx,
    input  logic             start,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] Nx_out,
    output logic [CNT_W-1:0] Nb_out,
    output logic             timeout,
    output logic             busy,
    output logic             gate_out,
    output logic [2:0]       o_dbg_state
);

    // One timer serves as the preset gate timer (GATE) and as the Fx wait timer
    // (ARM, CLOSE). It is sized for the larger of the two limits.
    localparam int TMR_MAX = ((GATE_TICKS - 1) > TIMEOUT_TICKS) ? (GATE_TICKS - 1) : TIMEOUT_TICKS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_TICKS - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_GATE  = 3'd2,
        S_CLOSE = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_rise;

    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_nx;
    logic [CNT_W-1:0] r_nb;

    logic             r_valid;
    logic             r_busy;
    logic             r_gate;
    logic             r_timeout;
    logic [CNT_W-1:0] r_nx_out;
    logic [CNT_W-1:0] r_nb_out;

    logic w_busy_d;
    logic w_gate_d;
    logic w_valid_d;
    logic w_tmo_hit;
    logic w_gate_hit;
    logic w_hs;
    logic w_close_ok;
    logic w_close_tmo;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Fx synchronizer and edge-detect flop. These flops are left out of reset
    // because they flush themselves within SYNC_STAGES+1 cycles.
    always_ff @(posedge CLK) begin
        r_sync   <= {r_sync[SYNC_STAGES-2:0], Fx};
        r_sync_d <= r_sync[SYNC_STAGES-1];
    end

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign w_tmo_hit  = (r_timer == TMO_LAST);
    assign w_gate_hit = (r_timer == GATE_LAST);
    assign w_hs       = r_valid & res_ready;

    // A valid result is latched on a closing rise, or on a rise that coincides
    // with gate expiry. The zeroed timeout result is latched on a wait expiry.
    assign w_close_ok  = ((r_state == S_GATE) && w_gate_hit && w_rise) ||
                         ((r_state == S_CLOSE) && w_rise);
    assign w_close_tmo = ((r_state == S_ARM) || (r_state == S_CLOSE)) && !w_rise && w_tmo_hit;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. An Fx rise wins over a wait-timer expiry in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ARM;
            end
            S_ARM: begin
                if (w_rise)         w_next = S_GATE;
                else if (w_tmo_hit) w_next = S_HOLD;
            end
            S_GATE: begin
                if (w_gate_hit) w_next = w_rise ? S_HOLD : S_CLOSE;
            end
            S_CLOSE: begin
                if (w_rise || w_tmo_hit) w_next = S_HOLD;
            end
            S_HOLD: begin
`ifdef FREQ_AUTO_RESTART_EN
                if (w_hs) w_next = S_ARM;
`else
                if (w_hs) w_next = S_IDLE;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state. The decoded values are registered below,
    // so busy, gate_out and res_valid follow a transition by one cycle.
    always_comb begin
        w_busy_d  = 1'b0;
        w_gate_d  = 1'b0;
        w_valid_d = 1'b0;
        case (w_next)
            S_ARM:   w_busy_d  = 1'b1;
            S_GATE:  begin w_busy_d = 1'b1; w_gate_d = 1'b1; end
            S_CLOSE: begin w_busy_d = 1'b1; w_gate_d = 1'b1; end
            S_HOLD:  w_valid_d = 1'b1;
            default: w_busy_d  = 1'b0;
        endcase
    end

    // Timer and the Nx/Nb counters. The opening edge counts as Nb=1. The
    // closing cycle is not added to Nb, so Nb equals K*P for K whole periods.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer <= '0;
            r_nx    <= '0;
            r_nb    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_timer <= '0;
                end
                S_ARM: begin
                    if (w_rise) begin
                        r_timer <= '0;
                        r_nx    <= '0;
                        r_nb    <= CNT_W'(1);
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_GATE: begin
                    if (w_rise) r_nx <= sat_inc(r_nx);
                    if (!(w_gate_hit && w_rise)) r_nb <= sat_inc(r_nb);
                    // On expiry the timer restarts as the CLOSE wait timer.
                    if (w_gate_hit) r_timer <= '0;
                    else            r_timer <= r_timer + TMR_W'(1);
                end
                S_CLOSE: begin
                    if (w_rise) r_nx <= sat_inc(r_nx);
                    else        r_nb <= sat_inc(r_nb);
                    r_timer <= r_timer + TMR_W'(1);
                end
                S_HOLD: begin
                    if (w_hs) r_timer <= '0;
                end
                default: r_timer <= '0;
            endcase
        end
    end

    // Registered outputs. The result is latched once per measurement and held
    // through HOLD.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy    <= 1'b0;
            r_gate    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_nx_out  <= '0;
            r_nb_out  <= '0;
        end else begin
            r_busy  <= w_busy_d;
            r_gate  <= w_gate_d;
            r_valid <= w_valid_d;
            if (w_close_ok) begin
                r_nx_out  <= sat_inc(r_nx);
                r_nb_out  <= r_nb;
                r_timeout <= 1'b0;
            end else if (w_close_tmo) begin
                r_nx_out  <= '0;
                r_nb_out  <= '0;
                r_timeout <= 1'b1;
            end
        end
    end

    assign res_valid   = r_valid;
    assign busy        = r_busy;
    assign gate_out    = r_gate;
    assign timeout     = r_timeout;
    assign Nx_out      = r_nx_out;
    assign Nb_out      = r_nb_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Testbench for freq_gate_ctrl.
// The whole stimulus is laid out in per-edge tables before time 0. A
// measurement-level reference model then derives the expected outputs after
// every edge. It finds the opening and closing rises from the Fx samples and
// applies the counting rules directly. A compare process checks the DUT after
// each edge, and a scoreboard queue checks each delivered result.
module tb_freq_gate_ctrl;

    localparam int G    = 100;
    localparam int T    = 500;
    localparam int W    = 7;
    localparam int S    = 2;
    localparam int NCYC = 7000;
    localparam int MAXV = (1 << W) - 1;
    localparam int RW   = 2 * W + 1;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Fx;
    logic         start;
    logic         res_ready;
    logic         res_valid;
    logic [W-1:0] Nx_out;
    logic [W-1:0] Nb_out;
    logic         timeout;
    logic         busy;
    logic         gate_out;
    logic [2:0]   dbg_state;

    freq_gate_ctrl #(
        .GATE_TICKS   (G),
        .TIMEOUT_TICKS(T),
        .CNT_W        (W),
        .SYNC_STAGES  (S)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Fx         (Fx),
        .start      (start),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .Nx_out     (Nx_out),
        .Nb_out     (Nb_out),
        .timeout    (timeout),
        .busy       (busy),
        .gate_out   (gate_out),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- stimulus tables (index = posedge number) ----------------
    bit rst_a[NCYC];
    bit fx_a[NCYC];
    bit start_a[NCYC];
    bit ready_a[NCYC];

    // ---------------- expected outputs after each edge ----------------
    bit e_known[NCYC];
    bit e_busy[NCYC];
    bit e_gate[NCYC];
    bit e_valid[NCYC];
    bit e_data[NCYC];
    bit e_to[NCYC];
    int e_nx[NCYC];
    int e_nb[NCYC];

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] model_res[$];

    int vectors     = 0;
    int miscompares = 0;
    int base        = 0;
    int seg3_start  = 0;

    // ---------------- stimulus builders ----------------
    // Fx has period per (0 means held low) and a 50% duty cycle.
    // ready is either high from rdy_from onward or random.
    function automatic void add_seg(input int len, input int per, input int ph, input int st1,
                                    input int st2, input int rdy_from, input int rst_at,
                                    input bit rnd_ready);
        for (int i = 0; i < len; i++) begin
            int n;
            n = base + i;
            if (n < NCYC) begin
                fx_a[n]    = (per > 0) ? (((i + ph) % per) >= (per / 2)) : 1'b0;
                start_a[n] = (i == st1) || (i == st2);
                rst_a[n]   = (i == rst_at);
                ready_a[n] = rnd_ready ? ($urandom_range(0, 2) == 0) : (i >= rdy_from);
            end
        end
        base = base + len;
    endfunction

    // ---------------- reference model ----------------
    // A rise is acted on S edges after the Fx sample that shows the new high level.
    function automatic bit rise_at(input int n);
        if (n < S + 1 || n >= NCYC) return 1'b0;
        return fx_a[n-S] && !fx_a[n-S-1];
    endfunction

    // Outcome of a measurement whose start is accepted at edge s. Returns the
    // opening edge o (-1 if none), the edge e after which the result is visible,
    // and the result itself.
    function automatic void predict(input int s, output int o, output int e, output bit to,
                                    output int nx, output int nb);
        int g;
        o = -1; e = -1; to = 1'b0; nx = 0; nb = 0;
        for (int j = s + 1; j <= s + 1 + T; j++) begin
            if (rise_at(j)) begin o = j; break; end
        end
        if (o < 0) begin
            e = s + 1 + T; to = 1'b1;
            return;
        end
        g = o + G;
        if (rise_at(g)) e = g;
        else begin
            for (int j = g + 1; j <= g + 1 + T; j++) begin
                if (rise_at(j)) begin e = j; break; end
            end
        end
        if (e < 0) begin
            e = g + 1 + T; to = 1'b1;
            return;
        end
        for (int j = o + 1; j <= e; j++) if (rise_at(j)) nx++;
        nb = e - o;
        if (nx > MAXV) nx = MAXV;
        if (nb > MAXV) nb = MAXV;
    endfunction

    function automatic void put(input int n, input bit bz, input bit gt, input bit vl,
                                input bit dt, input bit to, input int nx, input int nb);
        if (n >= NCYC) return;
        e_known[n] = 1'b1; e_busy[n] = bz; e_gate[n] = gt; e_valid[n] = vl;
        e_data[n]  = dt;   e_to[n]   = to; e_nx[n]   = nx; e_nb[n]    = nb;
    endfunction

    function automatic void build_model();
        int k, s, o, e, nx, nb, j;
        bit to, fin;
        k = 0;
        while (k < NCYC) begin
            if (rst_a[k]) begin
                put(k, 0, 0, 0, 1, 0, 0, 0);
                k++;
            end else if (!start_a[k]) begin
                put(k, 0, 0, 0, 0, 0, 0, 0);
                k++;
            end else begin
                s = k; fin = 1'b0;
                while (!fin) begin
                    predict(s, o, e, to, nx, nb);
                    put(s, 1, 0, 0, 0, 0, 0, 0);
                    j = s + 1;
                    while (j < NCYC) begin
                        if (rst_a[j]) break;
                        if (j < e) put(j, 1, (o >= 0) && (j >= o), 0, 0, 0, 0, 0);
                        else if (j == e) begin
                            put(j, 0, 0, 1, 1, to, nx, nb);
                            exp_q.push_back({to, W'(nx), W'(nb)});
                            model_res.push_back({to, W'(nx), W'(nb)});
                        end else if (ready_a[j]) break;
                        else put(j, 0, 0, 1, 1, to, nx, nb);
                        j++;
                    end
                    if (j >= NCYC) begin
                        fin = 1'b1; k = NCYC;
                    end else if (rst_a[j]) begin
                        put(j, 0, 0, 0, 1, 0, 0, 0);
                        fin = 1'b1; k = j + 1;
                    end else begin
`ifdef FREQ_AUTO_RESTART_EN
                        s = j;
`else
                        put(j, 0, 0, 0, 0, 0, 0, 0);
                        fin = 1'b1; k = j + 1;
`endif
                    end
                end
            end
        end
    endfunction

    // ---------------- comparison helper ----------------
    task automatic chk(input string nm, input int n, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
        end
    endtask

    // ---------------- build tables, model, then drive ----------------
    initial begin
        int per, ph, rs;
        for (int n = 0; n < 6; n++) begin
            rst_a[n] = 1'b1; fx_a[n] = 1'b0; start_a[n] = 1'b0; ready_a[n] = 1'b0;
        end
        base = 6;
        // Period 8, result held for about 60 cycles before ready.
        add_seg(300, 8, 0, 5, -1, 170, -1, 1'b0);
        // Period 10: the rise lands exactly on gate expiry.
        add_seg(250, 10, 3, 5, -1, 130, -1, 1'b0);
        // Fx held low: ARM wait timeout.
        seg3_start = base + 5;
        add_seg(700, 0, 0, 5, -1, 600, -1, 1'b0);
        // Reset inside the gate, then a fresh start.
        add_seg(500, 8, 5, 5, 80, 250, 55, 1'b0);
        // A single Fx rise opens the gate; no closing edge arrives, so CLOSE times out.
        add_seg(900, 1400, 690, 3, -1, 650, -1, 1'b0);
        // Random periods, phases, start pulses, ready and occasional reset.
        for (int r = 0; r < 12; r++) begin
            per = $urandom_range(2, 40);
            ph  = $urandom_range(0, per - 1);
            rs  = ($urandom_range(0, 5) == 0) ? $urandom_range(30, 200) : -1;
            add_seg(350, per, ph, $urandom_range(1, 20), $urandom_range(100, 340), 0, rs, 1'b1);
        end
        // Idle tail: Fx low, ready high.
        for (int n = base; n < NCYC; n++) begin
            rst_a[n] = 1'b0; fx_a[n] = 1'b0; start_a[n] = 1'b0; ready_a[n] = 1'b1;
        end
        build_model();

        for (int n = 0; n < NCYC; n++) begin
            RST = rst_a[n]; Fx = fx_a[n]; start = start_a[n]; res_ready = ready_a[n];
            @(posedge CLK);
            #1;
        end
    end

    // ---------------- compare process and scoreboard ----------------
    initial begin
        logic          prev_v;
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        int            cap_nx[$];
        int            cap_nb[$];
        int            cap_to[$];
        int            cap_edge[$];
        prev_v = 1'b0;
        for (int n = 0; n < NCYC; n++) begin
            @(posedge CLK);
            #2;
            if (e_known[n]) begin
                chk("busy", n, int'(busy), int'(e_busy[n]));
                chk("gate_out", n, int'(gate_out), int'(e_gate[n]));
                chk("res_valid", n, int'(res_valid), int'(e_valid[n]));
                if (e_data[n]) begin
                    chk("Nx_out", n, int'(Nx_out), e_nx[n]);
                    chk("Nb_out", n, int'(Nb_out), e_nb[n]);
                    chk("timeout", n, int'(timeout), int'(e_to[n]));
                end
                if (res_valid === 1'b1 && prev_v !== 1'b1) begin
                    got = {timeout, Nx_out, Nb_out};
                    cap_nx.push_back(int'(Nx_out));
                    cap_nb.push_back(int'(Nb_out));
                    cap_to.push_back(int'(timeout));
                    cap_edge.push_back(n);
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_result", n, 1, 0);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("sb_result", n, int'(got), int'(exp));
                    end
                end
                prev_v = res_valid;
            end
        end
        chk("sb_results_left", NCYC, exp_q.size(), 0);

        // Hand-computed results of the directed segments.
        if (model_res.size() < 5) chk("model_result_count", NCYC, model_res.size(), 5);
        else begin
            chk("model_pin_p8", 0, int'(model_res[0]), int'({1'b0, W'(13), W'(104)}));
            chk("model_pin_p10", 1, int'(model_res[1]), int'({1'b0, W'(10), W'(100)}));
            chk("model_pin_tmo", 2, int'(model_res[2]), int'({1'b1, W'(0), W'(0)}));
        end
        if (cap_nx.size() < 5) chk("dut_result_count", NCYC, cap_nx.size(), 5);
        else begin
            chk("p8_Nx", 0, cap_nx[0], 13);
            chk("p8_Nb", 0, cap_nb[0], 104);
            chk("p8_timeout", 0, cap_to[0], 0);
            chk("p10_Nx", 1, cap_nx[1], 10);
            chk("p10_Nb", 1, cap_nb[1], 100);
            chk("arm_tmo_flag", 2, cap_to[2], 1);
            chk("arm_tmo_Nx", 2, cap_nx[2], 0);
            chk("arm_tmo_Nb", 2, cap_nb[2], 0);
            chk("arm_tmo_latency", 2, cap_edge[2] - seg3_start, 501);
            chk("after_rst_Nx", 3, cap_nx[3], 13);
            chk("after_rst_Nb", 3, cap_nb[3], 104);
            chk("close_tmo_flag", 4, cap_to[4], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Measurement sequencer for the equal-precision frequency meter.
- Opens and closes the actual gate on synchronized Fx rising edges around a preset gate time.
- Counts reference cycles (Fb = CLK) and Fx periods inside the gate.
- Hands the (Nx, Nb) pair to the downstream divide/convert stage over a valid/ready handshake; the LCD path shows the result.

Parameters:
- GATE_TICKS, 50_000_000: preset gate length in CLK cycles (1 s at 50 MHz).
- TIMEOUT_TICKS, 100_000_000: maximum CLK cycles to wait for an Fx edge in ARM or CLOSE.
- CNT_W, 32: width of the Nx and Nb counters.
- SYNC_STAGES, 2: synchronizer depth for Fx (minimum 2).

Ports:
- CLK  in  1  system clock, 50 MHz; also the reference Fb.
- RST  in  1  synchronous, active-high reset.
- Fx  in  1  asynchronous input signal under measurement.
- start  in  1  single-cycle request to begin a measurement.
- res_ready  in  1  downstream accepts the result.
- res_valid  out  1  Nx_out/Nb_out/timeout valid.
- Nx_out  out  CNT_W  Fx periods counted inside the actual gate.
- Nb_out  out  CNT_W  CLK cycles counted inside the actual gate.
- timeout  out  1  result is invalid: no Fx edge arrived in time.
- busy  out  1  high in ARM, GATE and CLOSE.
- gate_out  out  1  actual gate, high in GATE and CLOSE.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset wins over every other input in the same cycle, including mid-measurement; the partial result is discarded.
- Fx path:
  - Fx passes through SYNC_STAGES flops, plus one flop for edge detection.
  - rise = sync & ~sync_d.
  - Latency from a pin edge to rise is SYNC_STAGES+1 cycles.
  - Fx periods shorter than 2 CLK cycles are out of range; results for them are undefined.
- IDLE:
  - start=1 moves to ARM; the wait timer is cleared.
  - start while busy or in HOLD is ignored.
- ARM:
  - Waits for rise. On rise: go to GATE, clear Nx/Nb, set Nb=1 (that cycle counts), clear the preset timer.
  - If the wait timer reaches TIMEOUT_TICKS: go to HOLD with timeout=1 and Nx_out=Nb_out=0.
- GATE:
  - Nb increments every cycle.
  - Nx increments on every rise after the opening one.
  - The preset timer increments every cycle; when it reaches GATE_TICKS-1, go to CLOSE.
  - If a rise coincides with expiry: the gate closes on that edge and the state goes directly to HOLD.
- CLOSE:
  - Nb increments every cycle except the closing cycle.
  - On rise: Nx increments, latch Nx/Nb into the outputs, go to HOLD, gate_out falls.
  - Wait timer runs from CLOSE entry; on expiry go to HOLD with timeout=1 and outputs 0.
- Counting rule: for Fx period P (clocks) and K periods inside the gate, the latched result is Nx=K and Nb=K*P exactly.
- Saturation: Nx and Nb saturate at all-ones and do not wrap.
- HOLD:
  - res_valid=1; outputs stay stable.
  - On res_valid & res_ready: res_valid falls the next cycle and the state goes to IDLE.
  - res_ready asserted outside HOLD is ignored.
- Output timing:
  - busy and gate_out are registered and change in the cycle after the state transition that drives them.
  - res_valid rises one cycle after the closing rise.

Optional Feature:
- Macro: FREQ_AUTO_RESTART_EN.
- Defined: after the HOLD handshake the state goes directly to ARM without start, giving continuous measurement. start is ignored, except when RST has left the block in IDLE, where start is still needed once.
- Undefined: every measurement requires a start pulse from IDLE.

Test Plan:
- GATE_TICKS=100, Fx period 8 clocks, start pulse -> res_valid once; Nx_out=13, Nb_out=104, timeout=0.
- GATE_TICKS=100, Fx period 10 with phase chosen so a rise coincides with preset expiry -> gate closes on that edge; Nx_out=10, Nb_out=100.
- TIMEOUT_TICKS=500, Fx held low, start -> timeout=1 and res_valid=1 on cycle 501 after ARM entry; Nx_out=Nb_out=0.
- Result held with res_ready=0 for 50 cycles, then ready=1 -> outputs stable throughout; res_valid falls the cycle after the handshake; busy=0.
- RST=1 asserted in GATE at cycle 40 -> all outputs 0 on the next cycle; a later start gives a correct fresh result (13/104 case).
- FREQ_AUTO_RESTART_EN defined, res_ready tied high -> back-to-back results 13/104 with no start pulses after the first.
